// File: rtl/bus_addr_decoder_pkg.sv
// Shared definitions for the data-bus decoder and the read-data return mux:
// target ids carried on sel_1d, FSM encoding, default address map, alignment rule.
package bus_addr_decoder_pkg;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [1:0] SEL_TIMER = 2'd2;
  localparam logic [1:0] SEL_TBMAN = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } state_t;

  localparam logic [31:0] DEF_MEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_MEM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] DEF_TIMER_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] DEF_TIMER_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] DEF_TBMAN_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_TBMAN_MASK = 32'hFFFF_F000;

  // Words need a word address, halves a half address, single bytes go anywhere.
  function automatic logic is_aligned(input logic [3:0] be, input logic [1:0] lsb);
    logic ok;
    case (be)
      4'b1111: ok = (lsb == 2'b00);
      4'b0011: ok = (lsb == 2'b00);
      4'b1100: ok = (lsb == 2'b10);
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bus_addr_decoder_if.sv
// CPU data-bus request side plus the decoded target-side strobes.
// master = CPU/bench side, slave = the decoder.
interface bus_addr_decoder_if;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_stall;

  logic        cs_mem_n;
  logic        cs_timer_n;
  logic        cs_tbman_n;
  logic        wr_en;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [1:0]  sel_1d;

  modport master (
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_stall, cs_mem_n, cs_timer_n, cs_tbman_n, wr_en,
           be_o, addr_o, wdata_o, sel_1d
  );

  modport slave (
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_stall, cs_mem_n, cs_timer_n, cs_tbman_n, wr_en,
           be_o, addr_o, wdata_o, sel_1d
  );

endinterface

// File: rtl/bus_addr_decoder_region_match.sv
// Single address-region comparator: hit when the masked address equals the base.
module bus_region_match #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter logic [31:0] MASK = 32'hFFFF_FFFF
) (
  input  logic [31:0] addr,
  output logic        hit
);

  assign hit = ((addr & MASK) == BASE);

endmodule

// File: rtl/bus_addr_decoder.sv
// Data-bus write/request decoder with read-latency stall FSM and sticky error register.
// Optional: BUS_ADDR_DECODER_ERR_CAPTURE_EN keeps bus_err/err_addr; otherwise they tie to 0.
module bus_addr_decoder
  import bus_addr_decoder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = DEF_MEM_BASE,
  parameter logic [31:0] MEM_MASK    = DEF_MEM_MASK,
  parameter logic [31:0] TIMER_BASE  = DEF_TIMER_BASE,
  parameter logic [31:0] TIMER_MASK  = DEF_TIMER_MASK,
  parameter logic [31:0] TBMAN_BASE  = DEF_TBMAN_BASE,
  parameter logic [31:0] TBMAN_MASK  = DEF_TBMAN_MASK,
  parameter int          MEM_RD_LAT  = 0,
  parameter int          PERI_RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  bus_addr_decoder_if.slave   bus,
  input  logic                err_clr,
  output logic                bus_err,
  output logic [31:0]         err_addr
);

  localparam logic [1:0] MEM_LAT  = 2'(MEM_RD_LAT);
  localparam logic [1:0] PERI_LAT = 2'(PERI_RD_LAT);

  logic       hit_mem, hit_timer, hit_tbman;
  logic [1:0] sel;
  logic       aligned, access_ok, fault, start_wait;
  logic [1:0] lat;
  logic [1:0] cnt;
  state_t     state;

  bus_region_match #(.BASE(MEM_BASE),   .MASK(MEM_MASK))   u_match_mem   (.addr(bus.d_addr), .hit(hit_mem));
  bus_region_match #(.BASE(TIMER_BASE), .MASK(TIMER_MASK)) u_match_timer (.addr(bus.d_addr), .hit(hit_timer));
  bus_region_match #(.BASE(TBMAN_BASE), .MASK(TBMAN_MASK)) u_match_tbman (.addr(bus.d_addr), .hit(hit_tbman));

  // Overlapping regions resolve timer first, then TBMAN, then memory.
  always_comb begin
    sel = SEL_NONE;
    if (hit_timer)      sel = SEL_TIMER;
    else if (hit_tbman) sel = SEL_TBMAN;
    else if (hit_mem)   sel = SEL_MEM;
  end

  assign aligned   = is_aligned(bus.d_be, bus.d_addr[1:0]);
  assign access_ok = reset_n & bus.d_req & (sel != SEL_NONE) & aligned;
  assign fault     = reset_n & bus.d_req & ~((sel != SEL_NONE) & aligned);

  assign lat        = (sel == SEL_MEM) ? MEM_LAT : PERI_LAT;
  assign start_wait = access_ok & ~bus.d_we & (lat != 2'd0);

  // The first stall cycle is raised straight from decode; later ones come from cnt.
  assign bus.d_stall = (state == ST_IDLE) ? start_wait
                                          : (reset_n & bus.d_req & (cnt != 2'd0));

  assign bus.cs_mem_n   = ~(access_ok & (sel == SEL_MEM));
  assign bus.cs_timer_n = ~(access_ok & (sel == SEL_TIMER));
  assign bus.cs_tbman_n = ~(access_ok & (sel == SEL_TBMAN));
  assign bus.wr_en      = access_ok & bus.d_we;

  assign bus.be_o    = bus.d_be;
  assign bus.addr_o  = bus.d_addr;
  assign bus.wdata_o = bus.d_wdata;

  // Read-latency FSM; sel_1d follows the winning target so the return mux lines up a cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      bus.sel_1d <= SEL_NONE;
    end else begin
      bus.sel_1d <= access_ok ? sel : SEL_NONE;
      case (state)
        ST_IDLE: begin
          if (start_wait) begin
            cnt   <= lat - 2'd1;
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!bus.d_req || cnt == 2'd0) state <= ST_IDLE;
          else                           cnt   <= cnt - 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_ADDR_DECODER_ERR_CAPTURE_EN
  // A new fault outranks a simultaneous clear; err_addr keeps the last fault after a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else if (fault) begin
      bus_err  <= 1'b1;
      err_addr <= bus.d_addr;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = ^{err_clr, fault};
  assign bus_err    = 1'b0;
  assign err_addr   = 32'h0;
`endif

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
- Write/request side of the CPU data bus: decodes the MEM-stage data address and drives active-low chip selects, write enable, byte strobes and write data to MEM, Timer and TBMAN.
- Complements the read-data return mux. Exports a registered target-select so the mux can be steered one cycle later.
- Stalls the pipeline for peripherals with synchronous read latency.
- Flags unmapped and misaligned accesses in a sticky error register.

Parameters:
- MEM_BASE, 32'h0000_0000, memory region base
- MEM_MASK, 32'hFFFF_0000, memory region match mask
- TIMER_BASE, 32'hFFFF_FF00, timer region base
- TIMER_MASK, 32'hFFFF_FF00, timer region match mask
- TBMAN_BASE, 32'h8000_0000, TBMAN region base
- TBMAN_MASK, 32'hFFFF_F000, TBMAN region match mask
- MEM_RD_LAT, 0, extra stall cycles for a memory read (0..3)
- PERI_RD_LAT, 1, extra stall cycles for a Timer/TBMAN read (0..3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- d_req  in  1  data access valid, held while d_stall=1
- d_we  in  1  1=write, 0=read
- d_be  in  4  byte enables
- d_addr  in  32  byte address
- d_wdata  in  32  write data
- d_stall  out  1  hold MEM stage
- cs_mem_n  out  1  memory chip select, active low
- cs_timer_n  out  1  timer chip select, active low
- cs_tbman_n  out  1  TBMAN chip select, active low
- wr_en  out  1  write strobe to the selected target
- be_o  out  4  byte enables to targets
- addr_o  out  32  address to targets
- wdata_o  out  32  write data to targets
- sel_1d  out  2  registered target id: 0=none, 1=mem, 2=timer, 3=tbman
- err_clr  in  1  clear the error flag
- bus_err  out  1  sticky error flag
- err_addr  out  32  faulting address

Behaviour:
- Reset values, applied on the clock edge with reset_n=0 and holding all outputs inactive:
  - cs_*_n=1, wr_en=0, d_stall=0, sel_1d=0, bus_err=0, err_addr=0.
  - FSM returns to IDLE and the latency counter clears.
- Decode is combinational and has no added latency: hit_x = ((d_addr & X_MASK) == X_BASE).
  - Priority when regions overlap: timer > tbman > mem.
  - Exactly one cs_*_n is low, and only when d_req=1.
- addr_o, wdata_o and be_o pass d_addr, d_wdata and d_be through unchanged.
- wr_en = d_req & d_we & valid hit & aligned.
- Alignment rules, all using d_addr[1:0]:
  - d_be=1111 needs 00.
  - d_be=0011 needs 00; d_be=1100 needs 10.
  - Single-byte enables are always aligned.
  - Any other be pattern is misaligned.
- Error case: an unmapped or misaligned access with d_req=1 asserts no cs and no wr_en.
  - bus_err is set next cycle and stays set until err_clr.
  - err_addr captures d_addr.
  - If err_clr and a new error occur in the same cycle, the new error wins.
- The access completes in the same cycle; there is no stall.
- sel_1d is registered every cycle from the current winning target, or 0 if d_req=0 or on error.
- FSM has two states, IDLE and RD_WAIT, with a 2-bit counter cnt.
  - IDLE: a read (d_req=1, d_we=0) to a target with lat L>0 asserts d_stall combinationally, sets cnt=L-1 and moves to RD_WAIT.
  - Writes never stall, and L=0 reads never stall.
  - RD_WAIT: d_stall=1 while cnt!=0, decrementing cnt each cycle.
  - When cnt==0, d_stall=0 and the FSM returns to IDLE; the access completes that cycle.
  - cs stays asserted throughout.
  - Total stall is L cycles.
- If d_req drops in RD_WAIT the access is aborted: d_stall=0 and the FSM returns to IDLE next cycle.
- A back-to-back read in the completion cycle's successor starts a new wait from IDLE.
- Reset in mid-wait returns the FSM to IDLE with d_stall=0 in the following cycle.

Optional Feature:
- Macro: BUS_ADDR_DECODER_ERR_CAPTURE_EN.
- Defined: bus_err and err_addr behave as specified above.
- Undefined: the error register is removed. bus_err=0 and err_addr=0 constantly, err_clr is ignored, and faulting accesses are still suppressed (no cs, no wr_en).

Decomposition:
- Shared package:
  - target-id localparams (SEL_NONE/MEM/TIMER/TBMAN)
  - FSM state encoding
  - default address-map constants, so the data mux and the decoder agree on both the map and sel_1d encoding
- One sub-module is natural: bus_region_match (mask/base compare, one instance per region).

Test Plan:
1. Write 0xDEADBEEF to 0x0000_0010 with be=1111: cs_mem_n=0 and wr_en=1 the same cycle, d_stall=0, sel_1d=1 next cycle.
2. Read 0xFFFF_FF04 with PERI_RD_LAT=1: cs_timer_n=0, d_stall=1 for 1 cycle then 0, sel_1d=2. Repeat with PERI_RD_LAT=3 for exactly 3 stall cycles.
3. Read 0x4000_0000 (unmapped): no cs, wr_en=0, bus_err=1 and err_addr=0x4000_0000 next cycle. err_clr pulsed together with an error at 0x0000_0002 (be=1111, misaligned): bus_err stays 1, err_addr=0x0000_0002.
4. Timer read stalled with PERI_RD_LAT=2: deassert d_req in the first wait cycle, expect d_stall=0 next cycle and FSM in IDLE. Separately, assert reset_n=0 mid-wait and expect all outputs at reset values.
5. Priority check: set TBMAN_BASE/MASK to overlap the timer region, access 0xFFFF_FF00, expect only cs_timer_n=0.
6. Build without BUS_ADDR_DECODER_ERR_CAPTURE_EN, repeat scenario 3: bus_err=0, err_addr=0, no cs asserted.
